ide_ram_cycle_ctrl: RTL and testbench

//  Sequences 68000 bus cycles that hit the board: Fast RAM (window decoded by the autoconfig block)
//  and IDE task-file registers. Sits between the CPU bus and the RAM/IDE devices.

---
 rtl/ide_ram_cycle_ctrl_pkg.sv | 20 ++
 rtl/ide_ram_cycle_ctrl_timer.sv | 26 ++
 rtl/ide_ram_cycle_ctrl.sv | 179 +++++++++++++++++
 tb/tb_ide_ram_cycle_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ide_ram_cycle_ctrl_pkg.sv
// State encoding and default timing constants shared by the cycle controller and its bench.
package ide_ram_cycle_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RAM_ACC,
        ST_IDE_SETUP,
        ST_IDE_STROBE,
        ST_ACK,
        ST_IDE_RECOV
    } state_t;

    localparam int DEF_RAM_WAIT    = 0;
    localparam int DEF_IDE_SETUP   = 1;
    localparam int DEF_IDE_ACTIVE  = 3;
    localparam int DEF_IDE_RECOVER = 2;
    localparam int DEF_IORDY_TMO   = 15;
    localparam int DEF_CNT_W       = 4;

endpackage

// File: rtl/ide_ram_cycle_ctrl_timer.sv
// Loadable down-counter for cycle timing; holds at zero instead of wrapping.
module ide_ram_cycle_ctrl_timer #(
    parameter int CNT_W = 4
) (
    input  logic             CLK,
    input  logic             _RST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (en && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ide_ram_cycle_ctrl.sv
// 68000 bus cycle sequencer for Fast RAM and IDE task-file accesses.
// Optional IDE_IORDY_EN: stretch the IDE strobe while IORDY is low, bounded by IORDY_TMO.
module ide_ram_cycle_ctrl
    import ide_ram_cycle_ctrl_pkg::*;
#(
    parameter int RAM_WAIT    = DEF_RAM_WAIT,
    parameter int IDE_SETUP   = DEF_IDE_SETUP,
    parameter int IDE_ACTIVE  = DEF_IDE_ACTIVE,
    parameter int IDE_RECOVER = DEF_IDE_RECOVER,
    parameter int IORDY_TMO   = DEF_IORDY_TMO,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic CLK,
    input  logic _RST,
    input  logic _AS,
    input  logic _UDS,
    input  logic _LDS,
    input  logic RW,
    input  logic ram_sel,
    input  logic ide_sel,
    input  logic ide_iordy,
    output logic DTACK,
    output logic _RAM_OE,
    output logic _RAM_WE_U,
    output logic _RAM_WE_L,
    output logic _IDE_IOR,
    output logic _IDE_IOW,
    output logic data_oe,
    output logic busy
);

    localparam logic [CNT_W-1:0] RAM_WAIT_C = CNT_W'(RAM_WAIT);
    localparam logic [CNT_W-1:0] SETUP_C    = CNT_W'(IDE_SETUP - 1);
    localparam logic [CNT_W-1:0] ACTIVE_C   = CNT_W'(IDE_ACTIVE - 1);
    localparam logic [CNT_W-1:0] RECOV_C    = CNT_W'(IDE_RECOVER - 1);

    state_t           state, nxt;
    logic             ide_cyc, rd, lane_u, lane_l;
    logic             nxt_ide, nxt_rd, nxt_u, nxt_l;
    logic             start, ram_on, ide_on;
    logic             tmr_ld, tmr_zero;
    logic [CNT_W-1:0] tmr_val;

`ifdef IDE_IORDY_EN
    localparam logic [CNT_W-1:0] TMO_C = CNT_W'(IORDY_TMO - 1);
    logic stretch, nxt_stretch;
`else
    logic unused_iordy;
    assign unused_iordy = ide_iordy | (IORDY_TMO == 0);
`endif

    ide_ram_cycle_ctrl_timer #(.CNT_W(CNT_W)) u_timer (
        .CLK      (CLK),
        ._RST     (_RST),
        .load     (tmr_ld),
        .load_val (tmr_val),
        .en       (state != ST_IDLE),
        .zero     (tmr_zero)
    );

    always_comb begin
        start   = !_AS && (!_UDS || !_LDS);
        nxt     = state;
        tmr_ld  = 1'b0;
        tmr_val = '0;
        nxt_ide = ide_cyc;
        nxt_rd  = rd;
        nxt_u   = lane_u;
        nxt_l   = lane_l;
`ifdef IDE_IORDY_EN
        nxt_stretch = stretch;
`endif
        case (state)
            ST_IDLE:
                if (start && (ram_sel || ide_sel)) begin
                    // RAM has priority when both windows decode
                    nxt_ide = !ram_sel;
                    nxt_rd  = RW;
                    nxt_u   = !_UDS;
                    nxt_l   = !_LDS;
                    tmr_ld  = 1'b1;
                    if (ram_sel) begin
                        nxt     = ST_RAM_ACC;
                        tmr_val = RAM_WAIT_C;
                    end else begin
                        nxt     = ST_IDE_SETUP;
                        tmr_val = SETUP_C;
                    end
                end
            ST_RAM_ACC:
                if (_AS)           nxt = ST_IDLE;
                else if (tmr_zero) nxt = ST_ACK;
            ST_IDE_SETUP:
                if (_AS) nxt = ST_IDE_RECOV;
                else if (tmr_zero) begin
                    nxt     = ST_IDE_STROBE;
                    tmr_ld  = 1'b1;
                    tmr_val = ACTIVE_C;
                end
`ifdef IDE_IORDY_EN
            ST_IDE_STROBE:
                if (_AS) nxt = ST_IDE_RECOV;
                else if (tmr_zero || stretch) begin
                    if (ide_iordy || (stretch && tmr_zero) || IORDY_TMO == 0)
                        nxt = ST_ACK;
                    else if (!stretch) begin
                        nxt_stretch = 1'b1;
                        tmr_ld      = 1'b1;
                        tmr_val     = TMO_C;
                    end
                end
`else
            ST_IDE_STROBE:
                if (_AS)           nxt = ST_IDE_RECOV;
                else if (tmr_zero) nxt = ST_ACK;
`endif
            ST_ACK:
                if (_AS) nxt = ide_cyc ? ST_IDE_RECOV : ST_IDLE;
            ST_IDE_RECOV:
                if (tmr_zero) nxt = ST_IDLE;
            default:
                nxt = ST_IDLE;
        endcase
        // Entering recovery loads the timer; a zero recovery skips the state
        if (nxt == ST_IDE_RECOV && state != ST_IDE_RECOV) begin
            if (IDE_RECOVER == 0)
                nxt = ST_IDLE;
            else begin
                tmr_ld  = 1'b1;
                tmr_val = RECOV_C;
            end
        end
`ifdef IDE_IORDY_EN
        if (nxt != ST_IDE_STROBE) nxt_stretch = 1'b0;
`endif
    end

    assign ram_on = (nxt == ST_RAM_ACC) || (nxt == ST_ACK && !nxt_ide);
    assign ide_on = (nxt == ST_IDE_STROBE) || (nxt == ST_ACK && nxt_ide);

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state     <= ST_IDLE;
            ide_cyc   <= 1'b0;
            rd        <= 1'b0;
            lane_u    <= 1'b0;
            lane_l    <= 1'b0;
`ifdef IDE_IORDY_EN
            stretch   <= 1'b0;
`endif
            DTACK     <= 1'b0;
            _RAM_OE   <= 1'b1;
            _RAM_WE_U <= 1'b1;
            _RAM_WE_L <= 1'b1;
            _IDE_IOR  <= 1'b1;
            _IDE_IOW  <= 1'b1;
            data_oe   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= nxt;
            ide_cyc   <= nxt_ide;
            rd        <= nxt_rd;
            lane_u    <= nxt_u;
            lane_l    <= nxt_l;
`ifdef IDE_IORDY_EN
            stretch   <= nxt_stretch;
`endif
            DTACK     <= (nxt == ST_ACK);
            _RAM_OE   <= !(ram_on && nxt_rd);
            _RAM_WE_U <= !(ram_on && !nxt_rd && nxt_u);
            _RAM_WE_L <= !(ram_on && !nxt_rd && nxt_l);
            _IDE_IOR  <= !(ide_on && nxt_rd);
            _IDE_IOW  <= !(ide_on && !nxt_rd);
            data_oe   <= (ram_on || ide_on) && nxt_rd;
            busy      <= (nxt != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_ide_ram_cycle_ctrl.sv
// Bench for ide_ram_cycle_ctrl: vector table, corner sequences and a random run against a transaction model.
module tb_ide_ram_cycle_ctrl;
    import ide_ram_cycle_ctrl_pkg::*;

    localparam int SETUP   = DEF_IDE_SETUP;
    localparam int ACTIVE  = DEF_IDE_ACTIVE;
    localparam int RECOVER = DEF_IDE_RECOVER;
    localparam logic [7:0] IDLE_O = 8'b0111_1100;

    logic clk = 1'b0;
    logic rst_n, as_n, uds_n, lds_n, rw, ram_sel, ide_sel, iordy;
    logic dtack_a, oe_a, weu_a, wel_a, ior_a, iow_a, doe_a, busy_a;
    logic dtack_b, oe_b, weu_b, wel_b, ior_b, iow_b, doe_b, busy_b;
    logic [7:0] out_a, out_b;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    // Transaction model state per DUT: 0 none, 1 RAM, 2 IDE
    int   m_act[2];
    int   m_t0[2];
    int   m_ack[2];
    int   m_idle_at[2];
    logic m_rd[2], m_u[2], m_l[2];
    int   m_wait[2] = '{0, 2};

    always #5 clk = ~clk;

    ide_ram_cycle_ctrl #(.RAM_WAIT(0)) u_dut_a (
        .CLK(clk), ._RST(rst_n), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n), .RW(rw),
        .ram_sel(ram_sel), .ide_sel(ide_sel), .ide_iordy(iordy),
        .DTACK(dtack_a), ._RAM_OE(oe_a), ._RAM_WE_U(weu_a), ._RAM_WE_L(wel_a),
        ._IDE_IOR(ior_a), ._IDE_IOW(iow_a), .data_oe(doe_a), .busy(busy_a)
    );

    ide_ram_cycle_ctrl #(.RAM_WAIT(2)) u_dut_b (
        .CLK(clk), ._RST(rst_n), ._AS(as_n), ._UDS(uds_n), ._LDS(lds_n), .RW(rw),
        .ram_sel(ram_sel), .ide_sel(ide_sel), .ide_iordy(iordy),
        .DTACK(dtack_b), ._RAM_OE(oe_b), ._RAM_WE_U(weu_b), ._RAM_WE_L(wel_b),
        ._IDE_IOR(ior_b), ._IDE_IOW(iow_b), .data_oe(doe_b), .busy(busy_b)
    );

    assign out_a = {dtack_a, oe_a, weu_a, wel_a, ior_a, iow_a, doe_a, busy_a};
    assign out_b = {dtack_b, oe_b, weu_b, wel_b, ior_b, iow_b, doe_b, busy_b};

    typedef struct packed {
        logic       as_n, uds_n, lds_n, rw, ram, ide;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl[32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input logic a, u, l, r, rs, is);
        as_n = a; uds_n = u; lds_n = l; rw = r; ram_sel = rs; ide_sel = is;
    endtask

    task automatic model_step(input int i, output logic [7:0] e);
        int  k;
        logic s;
        k = cyc;
        if (m_act[i] == 0) begin
            if (k >= m_idle_at[i] && !as_n && (!uds_n || !lds_n) && (ram_sel || ide_sel)) begin
                m_act[i] = ram_sel ? 1 : 2;
                m_t0[i]  = k;
                m_rd[i]  = rw;
                m_u[i]   = !uds_n;
                m_l[i]   = !lds_n;
                m_ack[i] = ram_sel ? k + m_wait[i] + 1 : k + SETUP + ACTIVE;
            end
        end else if (as_n) begin
            m_idle_at[i] = (m_act[i] == 1) ? k + 1 : k + RECOVER + 1;
            m_act[i] = 0;
        end
        if (m_act[i] == 1)
            e = {k >= m_ack[i], !m_rd[i], !(!m_rd[i] && m_u[i]), !(!m_rd[i] && m_l[i]),
                 1'b1, 1'b1, m_rd[i], 1'b1};
        else if (m_act[i] == 2) begin
            s = (k >= m_t0[i] + SETUP);
            e = {k >= m_ack[i], 1'b1, 1'b1, 1'b1, !(s && m_rd[i]), !(s && !m_rd[i]),
                 s && m_rd[i], 1'b1};
        end else
            e = {IDLE_O[7:1], k < m_idle_at[i] - 1};
    endtask

    task automatic tick(input bit use_model);
        logic [7:0] ea, eb;
        @(posedge clk);
        #1;
        cyc++;
        if (use_model) begin
            model_step(0, ea);
            model_step(1, eb);
            chk("rand_a", {24'd0, out_a}, {24'd0, ea});
            chk("rand_b", {24'd0, out_b}, {24'd0, eb});
        end
    endtask

    initial begin
        logic [1:0] sel;
        int hold, gap, lanes;
`ifdef IDE_IORDY_EN
        int got;
`endif
        tbl[0]  = '{1,1,1,1,0,0, 8'b0111_1100};
        tbl[1]  = '{0,0,0,1,1,0, 8'b0011_1111};
        tbl[2]  = '{0,0,0,1,1,0, 8'b1011_1111};
        tbl[3]  = '{0,0,0,1,1,0, 8'b1011_1111};
        tbl[4]  = '{1,1,1,1,0,0, 8'b0111_1100};
        tbl[5]  = '{0,0,0,1,0,1, 8'b0111_1101};
        tbl[6]  = '{0,0,0,1,0,1, 8'b0111_0111};
        tbl[7]  = '{0,0,0,1,0,1, 8'b0111_0111};
        tbl[8]  = '{0,0,0,1,0,1, 8'b0111_0111};
        tbl[9]  = '{0,0,0,1,0,1, 8'b1111_0111};
        tbl[10] = '{1,1,1,1,0,0, 8'b0111_1101};
        tbl[11] = '{0,0,0,1,0,1, 8'b0111_1101};
        tbl[12] = '{0,0,0,1,0,1, 8'b0111_1100};
        tbl[13] = '{0,0,0,1,0,1, 8'b0111_1101};
        tbl[14] = '{0,0,0,1,0,1, 8'b0111_0111};
        tbl[15] = '{1,1,1,1,0,0, 8'b0111_1101};
        tbl[16] = '{1,1,1,1,0,0, 8'b0111_1101};
        tbl[17] = '{1,1,1,1,0,0, 8'b0111_1100};
        tbl[18] = '{0,1,0,0,0,1, 8'b0111_1101};
        tbl[19] = '{0,1,0,0,0,1, 8'b0111_1001};
        tbl[20] = '{0,1,0,0,0,1, 8'b0111_1001};
        tbl[21] = '{0,1,0,0,0,1, 8'b0111_1001};
        tbl[22] = '{0,1,0,0,0,1, 8'b1111_1001};
        tbl[23] = '{1,1,1,1,0,0, 8'b0111_1101};
        tbl[24] = '{1,1,1,1,0,0, 8'b0111_1101};
        tbl[25] = '{1,1,1,1,0,0, 8'b0111_1100};
        tbl[26] = '{0,0,1,0,1,1, 8'b0101_1101};
        tbl[27] = '{0,0,1,0,1,1, 8'b1101_1101};
        tbl[28] = '{1,1,1,1,0,0, 8'b0111_1100};
        tbl[29] = '{0,1,1,1,1,0, 8'b0111_1100};
        tbl[30] = '{0,0,0,1,0,0, 8'b0111_1100};
        tbl[31] = '{1,1,1,1,0,0, 8'b0111_1100};

        rst_n = 1'b0;
`ifdef IDE_IORDY_EN
        iordy = 1'b1;
`else
        iordy = 1'b0;
`endif
        drive(1, 1, 1, 1, 0, 0);
        repeat (3) tick(0);
        chk("reset_a", {24'd0, out_a}, {24'd0, IDLE_O});
        chk("reset_b", {24'd0, out_b}, {24'd0, IDLE_O});
        rst_n = 1'b1;
        tick(0);

        for (int i = 0; i < 32; i++) begin
            drive(tbl[i].as_n, tbl[i].uds_n, tbl[i].lds_n, tbl[i].rw, tbl[i].ram, tbl[i].ide);
            tick(0);
            chk($sformatf("vec%0d", i), {24'd0, out_a}, {24'd0, tbl[i].exp});
        end
        repeat (4) tick(0);

        // RAM upper-byte write with two wait cycles
        drive(0, 0, 1, 0, 1, 0);
        for (int j = 0; j < 4; j++) begin
            tick(0);
            chk($sformatf("ramwr_w2_%0d", j), {24'd0, out_b},
                {24'd0, (j == 3) ? 8'b1101_1101 : 8'b0101_1101});
        end
        drive(1, 1, 1, 1, 0, 0);
        tick(0);
        chk("ramwr_w2_rel", {24'd0, out_b}, {24'd0, IDLE_O});
        repeat (3) tick(0);

        // Asynchronous reset in the middle of a RAM access
        drive(0, 0, 0, 1, 1, 0);
        tick(0);
        chk("rst_mid_pre", {24'd0, out_b}, {24'd0, 8'b0011_1111});
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_a", {24'd0, out_a}, {24'd0, IDLE_O});
        chk("rst_mid_b", {24'd0, out_b}, {24'd0, IDLE_O});
        drive(1, 1, 1, 1, 0, 0);
        tick(0);
        rst_n = 1'b1;
        tick(0);
        chk("rst_after", {24'd0, out_b}, {24'd0, IDLE_O});
        repeat (2) tick(0);

`ifdef IDE_IORDY_EN
        for (int pass = 0; pass < 2; pass++) begin
            iordy = 1'b0;
            drive(0, 0, 0, 1, 0, 1);
            tick(0);
            got = 0;
            for (int j = 1; j <= 40; j++) begin
                tick(0);
                if (pass == 1 && j == 6) iordy = 1'b1;
                if (dtack_a) begin
                    got = j;
                    break;
                end
            end
            chk(pass == 0 ? "iordy_tmo" : "iordy_rise", got, (pass == 0) ? 19 : 7);
            iordy = 1'b1;
            drive(1, 1, 1, 1, 0, 0);
            repeat (5) tick(0);
        end
`endif

        for (int i = 0; i < 2; i++) begin
            m_act[i] = 0;
            m_idle_at[i] = 0;
        end
        for (int t = 0; t < 250; t++) begin
            sel   = 2'($urandom_range(0, 3));
            hold  = $urandom_range(1, 10);
            gap   = $urandom_range(1, 4);
            lanes = $urandom_range(0, 7);
`ifndef IDE_IORDY_EN
            iordy = 1'($urandom);
`endif
            case (lanes)
                0:       drive(0, 1, 1, 1'($urandom), sel[0], sel[1]);
                1, 2:    drive(0, 0, 1, 1'($urandom), sel[0], sel[1]);
                3, 4:    drive(0, 1, 0, 1'($urandom), sel[0], sel[1]);
                default: drive(0, 0, 0, 1'($urandom), sel[0], sel[1]);
            endcase
            repeat (hold) tick(1);
            drive(1, 1, 1, 1, 0, 0);
            repeat (gap) tick(1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
